dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Shares the single data-cache port (2-way, 4-set cache; addr/write_data/write_en/func3 in, read_data/hit/busy out) between the instruction-fetch requester (port 0, read-only) and the load/store unit (port 1, read/write).
- Grants one requester at a time, holds the cache inputs stable for the whole operation and detects completion from hit/busy.
- Returns a one-cycle response per requester and flags operations that time out or are misaligned.

Parameters:
- STARVE_LIMIT, 4, consecutive LSU grants allowed while IF is pending before IF is forced to win.
- TIMEOUT, 20, max cycles in WAIT before the operation is aborted with error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- if_req_valid  in  1  IF read request
- if_req_addr  in  32  IF word address
- if_req_ready  out  1  IF request accepted this cycle
- if_resp_valid  out  1  one-cycle IF response pulse
- if_resp_rdata  out  32  IF read data
- if_resp_err  out  1  IF response is an error
- ls_req_valid  in  1  LSU request
- ls_req_addr  in  32  LSU address
- ls_req_wdata  in  32  LSU store data
- ls_req_we  in  1  1 = store
- ls_req_func3  in  3  000 byte, 001 half, 010 word
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_resp_valid  out  1  one-cycle LSU response pulse
- ls_resp_rdata  out  32  LSU load data; 0 for stores
- ls_resp_err  out  1  LSU response is an error
- c_addr  out  32  cache address
- c_wdata  out  32  cache write data
- c_we  out  1  cache write enable
- c_func3  out  3  cache access size
- c_rdata  in  32  cache read data
- c_hit  in  1  cache hit
- c_busy  in  1  cache busy
- err_sticky  out  1  set on any timeout; cleared only by reset

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (reset==0 at posedge): state IDLE; all outputs 0 except c_func3 = 3'b010; starvation counter 0; any outstanding operation is dropped with no response.
- IDLE arbitration (combinational ready):
  - LSU wins when ls_req_valid, unless if_req_valid and starve_cnt == STARVE_LIMIT.
  - Otherwise IF wins if if_req_valid.
  - Only the winner's ready is high; at most one ready per cycle.
- On accept (valid & ready), latch addr/wdata/we/func3 (IF: we=0, func3=010) and the owner ID.
- Starvation counter:
  - Increments on an LSU grant while if_req_valid = 1; saturates at STARVE_LIMIT.
  - Clears on an IF grant, or on an LSU grant with if_req_valid = 0.
- Misalignment: LSU half with addr[0]=1, word with addr[1:0]!=0, or func3 not 000/001/010.
  - Accepted, then goes directly to RESP with err=1; no cache access, c_* unchanged.
- ISSUE (1 cycle): drive c_* from the latches. c_we = latched we.
- WAIT:
  - Keep c_* stable.
  - Complete when c_busy==0 and (c_we==1 or c_hit==1); capture c_rdata (0 if store) and go to RESP.
  - Timeout: a cycle counter starts at 0 on WAIT entry. If it reaches TIMEOUT without completion, go to RESP with err=1 and set err_sticky.
- RESP (1 cycle):
  - Owner's resp_valid = 1 with the captured rdata and err.
  - c_we = 0.
  - Next state IDLE; a new grant is possible in the next cycle.
- Minimum latency: accept at cycle N → resp_valid at N+3. No request is accepted while not IDLE.
- A requester must not drop or change its request once accepted; requests held while not ready are simply not accepted.
- Both valid in the same cycle is resolved purely by the priority rule above.
- Outputs are registered except *_req_ready.

Decomposition:
- Shared package (mem_pkg): state encoding (IDLE, ISSUE, WAIT, RESP), func3 constants (FUNC3_B=000, FUNC3_H=001, FUNC3_W=010), requester IDs (REQ_IF=0, REQ_LS=1).
- One natural sub-module: arb_prio_starve (2-way priority pick plus saturating starvation counter); the FSM and datapath latches stay in the top level.

Test Plan:
- LSU store word 0x00000010 ← 0x11111111; then IF read 0x00000010 with a cache-stub hit on the 2nd WAIT cycle → ls_resp_valid at N+3; if_resp_rdata = 0x11111111, err = 0.
- Both valid every cycle, STARVE_LIMIT=4 → grant order LS, LS, LS, LS, IF, LS…; never two readys in one cycle.
- Stub holds c_busy=1 forever → resp_valid with err=1 exactly TIMEOUT+1 cycles after ISSUE; err_sticky = 1 and stays 1 until reset.
- LSU half load at 0x00000105 → ls_resp_err = 1 at N+1; c_addr never changes to 0x105.
- reset=0 asserted during WAIT → next cycle IDLE, c_we=0, no resp_valid ever for that operation; a fresh request is served normally afterwards.
- Byte store 0x100 ← 0x12345678 (func3=000): c_func3 = 000 and c_wdata = 0x12345678 held stable through ISSUE and WAIT; c_we drops in RESP.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-cache port arbiter
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] FUNC3_B = 3'b000;
  localparam logic [2:0] FUNC3_H = 3'b001;
  localparam logic [2:0] FUNC3_W = 3'b010;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  // An LSU access is rejected when its size is unsupported or its address is
  // not naturally aligned to that size.
  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    logic bad;
    case (func3)
      FUNC3_B: bad = 1'b0;
      FUNC3_H: bad = addr_lo[0];
      FUNC3_W: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// rtl/arb_prio_starve.sv - LSU-priority two-way pick with IF starvation guard
module arb_prio_starve
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic if_valid,
  input  logic ls_valid,
  output logic if_grant,
  output logic ls_grant
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          force_if;

  // LSU wins by default; IF wins once the LSU has been favoured STARVE_LIMIT times in a row.
  always_comb begin
    force_if = if_valid && (starve_cnt == CW'(STARVE_LIMIT));
    ls_grant = enable && ls_valid && !force_if;
    if_grant = enable && if_valid && !ls_grant;
  end

  // Count LSU grants that bypassed a waiting IF request; any other grant clears the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (ls_grant) begin
      if (if_valid) begin
        if (starve_cnt != CW'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + CW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end else if (if_grant) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - shares the data-cache port between IF and LSU
module dcache_port_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_rdata,
  output logic        if_resp_err,
  input  logic        ls_req_valid,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  input  logic        ls_req_we,
  input  logic [2:0]  ls_req_func3,
  output logic        ls_req_ready,
  output logic        ls_resp_valid,
  output logic [31:0] ls_resp_rdata,
  output logic        ls_resp_err,
  output logic [31:0] c_addr,
  output logic [31:0] c_wdata,
  output logic        c_we,
  output logic [2:0]  c_func3,
  input  logic [31:0] c_rdata,
  input  logic        c_hit,
  input  logic        c_busy,
  output logic        err_sticky
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q;
  state_t        state_d;
  logic          owner_q;
  logic [TW-1:0] wait_cnt_q;
  logic          arb_enable;
  logic          ls_mis;
  logic          op_done;
  logic          op_timeout;

  assign arb_enable = (state_q == IDLE) && reset;
  assign ls_mis     = is_misaligned(ls_req_func3, ls_req_addr[1:0]);
  assign op_done    = !c_busy && (c_we || c_hit);
  assign op_timeout = (wait_cnt_q == TW'(TIMEOUT - 1));

  arb_prio_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .enable   (arb_enable),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .if_grant (if_req_ready),
    .ls_grant (ls_req_ready)
  );

  // Next-state: misaligned LSU requests skip the cache and report straight away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ls_req_ready && ls_mis) begin
          state_d = RESP;
        end else if (ls_req_ready || if_req_ready) begin
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (op_done || op_timeout) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, cache-side drive and registered response pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= REQ_IF;
      wait_cnt_q    <= '0;
      c_addr        <= '0;
      c_wdata       <= '0;
      c_we          <= 1'b0;
      c_func3       <= FUNC3_W;
      if_resp_valid <= 1'b0;
      if_resp_rdata <= '0;
      if_resp_err   <= 1'b0;
      ls_resp_valid <= 1'b0;
      ls_resp_rdata <= '0;
      ls_resp_err   <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      state_q       <= state_d;
      if_resp_valid <= 1'b0;
      if_resp_err   <= 1'b0;
      ls_resp_valid <= 1'b0;
      ls_resp_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ls_req_ready) begin
            owner_q <= REQ_LS;
            if (ls_mis) begin
              ls_resp_valid <= 1'b1;
              ls_resp_err   <= 1'b1;
              ls_resp_rdata <= '0;
            end else begin
              c_addr  <= ls_req_addr;
              c_wdata <= ls_req_wdata;
              c_we    <= ls_req_we;
              c_func3 <= ls_req_func3;
            end
          end else if (if_req_ready) begin
            owner_q <= REQ_IF;
            c_addr  <= if_req_addr;
            c_wdata <= '0;
            c_we    <= 1'b0;
            c_func3 <= FUNC3_W;
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + TW'(1);
          if (op_done || op_timeout) begin
            c_we <= 1'b0;
            if (owner_q == REQ_LS) begin
              ls_resp_valid <= 1'b1;
              ls_resp_err   <= !op_done;
              ls_resp_rdata <= (op_done && !c_we) ? c_rdata : 32'd0;
            end else begin
              if_resp_valid <= 1'b1;
              if_resp_err   <= !op_done;
              if_resp_rdata <= op_done ? c_rdata : 32'd0;
            end
            if (!op_done) begin
              err_sticky <= 1'b1;
            end
          end
        end
        default: begin
          c_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - directed self-checking bench for dcache_port_arbiter
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_rdata;
  logic        if_resp_err;
  logic        ls_req_valid;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_we;
  logic [2:0]  ls_req_func3;
  logic        ls_req_ready;
  logic        ls_resp_valid;
  logic [31:0] ls_resp_rdata;
  logic        ls_resp_err;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_we;
  logic [2:0]  c_func3;
  logic [31:0] c_rdata;
  logic        c_hit;
  logic        c_busy;
  logic        err_sticky;

  logic [31:0] mem [0:255];
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_req_we(ls_req_we), .ls_req_func3(ls_req_func3), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata), .ls_resp_err(ls_resp_err),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we), .c_func3(c_func3),
    .c_rdata(c_rdata), .c_hit(c_hit), .c_busy(c_busy), .err_sticky(err_sticky)
  );

  // Cache stub: word memory written whenever a store is presented and not busy.
  assign c_rdata = mem[c_addr[9:2]];
  always @(posedge clk) begin
    if (c_we && !c_busy) mem[c_addr[9:2]] <= c_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    int ng;
    logic grants [0:5];
    logic exp_grants [0:5];
    logic seen_resp;

    exp_grants[0] = 1'b1; exp_grants[1] = 1'b1; exp_grants[2] = 1'b1;
    exp_grants[3] = 1'b1; exp_grants[4] = 1'b0; exp_grants[5] = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    reset = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_we = 1'b0; ls_req_func3 = 3'b010;
    c_hit = 1'b0; c_busy = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_c_func3", {29'd0, c_func3}, 32'd2);
    chk("rst_c_we", {31'd0, c_we}, 32'd0);
    chk("rst_c_addr", c_addr, 32'd0);
    chk("rst_resp_valid", {30'd0, if_resp_valid, ls_resp_valid}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    reset = 1'b1;
    tick();

    // LSU store word 0x10 <- 0x11111111
    ls_req_valid = 1'b1; ls_req_addr = 32'h10; ls_req_wdata = 32'h11111111;
    ls_req_we = 1'b1; ls_req_func3 = 3'b010;
    #1;
    chk("st_ls_ready", {31'd0, ls_req_ready}, 32'd1);
    chk("st_if_ready", {31'd0, if_req_ready}, 32'd0);
    tick(); ls_req_valid = 1'b0;
    chk("st_issue_addr", c_addr, 32'h10);
    chk("st_issue_we", {31'd0, c_we}, 32'd1);
    tick();
    chk("st_wait_nresp", {31'd0, ls_resp_valid}, 32'd0);
    tick();
    chk("st_resp_valid", {31'd0, ls_resp_valid}, 32'd1);
    chk("st_resp_rdata", ls_resp_rdata, 32'd0);
    chk("st_resp_err", {31'd0, ls_resp_err}, 32'd0);
    chk("st_resp_we", {31'd0, c_we}, 32'd0);
    tick();
    chk("st_pulse_end", {31'd0, ls_resp_valid}, 32'd0);

    // IF read 0x10, hit on second WAIT cycle
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1;
    chk("ld_if_ready", {31'd0, if_req_ready}, 32'd1);
    tick(); if_req_valid = 1'b0;
    chk("ld_issue_func3", {29'd0, c_func3}, 32'd2);
    tick();
    chk("ld_wait1_nresp", {31'd0, if_resp_valid}, 32'd0);
    tick(); c_hit = 1'b1;
    chk("ld_wait2_nresp", {31'd0, if_resp_valid}, 32'd0);
    tick(); c_hit = 1'b0;
    chk("ld_resp_valid", {31'd0, if_resp_valid}, 32'd1);
    chk("ld_resp_rdata", if_resp_rdata, 32'h11111111);
    chk("ld_resp_err", {31'd0, if_resp_err}, 32'd0);
    tick();

    // starvation: both valid continuously
    c_hit = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    ls_req_valid = 1'b1; ls_req_addr = 32'h20; ls_req_wdata = 32'h5a5a5a5a;
    ls_req_we = 1'b1; ls_req_func3 = 3'b010;
    #1;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
      chk("arb_one_ready", {31'd0, if_req_ready & ls_req_ready}, 32'd0);
      if (ls_req_ready) begin
        grants[ng] = 1'b1; ng++;
      end else if (if_req_ready) begin
        grants[ng] = 1'b0; ng++;
      end
      if (ng == 6) begin
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
      end
      tick();
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    chk("arb_grant_count", ng, 32'd6);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("arb_grant%0d_is_ls", i), {31'd0, grants[i]}, {31'd0, exp_grants[i]});
    end
    tick(); tick(); tick(); tick();
    c_hit = 1'b0;

    // timeout with cache stuck busy
    c_busy = 1'b1;
    chk("to_sticky_before", {31'd0, err_sticky}, 32'd0);
    ls_req_valid = 1'b1; ls_req_addr = 32'h30; ls_req_we = 1'b0; ls_req_func3 = 3'b010;
    #1;
    chk("to_ls_ready", {31'd0, ls_req_ready}, 32'd1);
    tick(); ls_req_valid = 1'b0;
    k = 0;
    while (!ls_resp_valid && k < 40) begin
      tick(); k++;
    end
    chk("to_latency_from_issue", k, 32'd21);
    chk("to_resp_err", {31'd0, ls_resp_err}, 32'd1);
    chk("to_sticky_set", {31'd0, err_sticky}, 32'd1);
    c_busy = 1'b0;
    tick(); tick(); tick();
    chk("to_sticky_holds", {31'd0, err_sticky}, 32'd1);

    // misaligned half load at 0x105
    ls_req_valid = 1'b1; ls_req_addr = 32'h105; ls_req_we = 1'b0; ls_req_func3 = 3'b001;
    #1;
    chk("mis_ready", {31'd0, ls_req_ready}, 32'd1);
    tick(); ls_req_valid = 1'b0;
    chk("mis_resp_valid", {31'd0, ls_resp_valid}, 32'd1);
    chk("mis_resp_err", {31'd0, ls_resp_err}, 32'd1);
    chk("mis_c_addr_n1", c_addr, 32'h30);
    tick();
    chk("mis_pulse_end", {31'd0, ls_resp_valid}, 32'd0);
    chk("mis_c_addr_n2", c_addr, 32'h30);

    // byte store 0x100 <- 0x12345678, two WAIT cycles
    c_busy = 1'b1;
    ls_req_valid = 1'b1; ls_req_addr = 32'h100; ls_req_wdata = 32'h12345678;
    ls_req_we = 1'b1; ls_req_func3 = 3'b000;
    #1;
    chk("bs_ready", {31'd0, ls_req_ready}, 32'd1);
    tick(); ls_req_valid = 1'b0; ls_req_wdata = 32'hdeadbeef; ls_req_func3 = 3'b010;
    chk("bs_issue_func3", {29'd0, c_func3}, 32'd0);
    chk("bs_issue_wdata", c_wdata, 32'h12345678);
    chk("bs_issue_addr", c_addr, 32'h100);
    tick();
    chk("bs_wait1_func3", {29'd0, c_func3}, 32'd0);
    chk("bs_wait1_wdata", c_wdata, 32'h12345678);
    chk("bs_wait1_we", {31'd0, c_we}, 32'd1);
    tick(); c_busy = 1'b0;
    chk("bs_wait2_wdata", c_wdata, 32'h12345678);
    chk("bs_wait2_we", {31'd0, c_we}, 32'd1);
    tick();
    chk("bs_resp_valid", {31'd0, ls_resp_valid}, 32'd1);
    chk("bs_resp_we", {31'd0, c_we}, 32'd0);
    tick();

    // reset asserted during WAIT drops the operation
    c_busy = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1;
    chk("rw_if_ready", {31'd0, if_req_ready}, 32'd1);
    tick(); if_req_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("rw_c_we", {31'd0, c_we}, 32'd0);
    chk("rw_c_func3", {29'd0, c_func3}, 32'd2);
    chk("rw_sticky_cleared", {31'd0, err_sticky}, 32'd0);
    reset = 1'b1; c_busy = 1'b0; c_hit = 1'b1;
    seen_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_resp = seen_resp | if_resp_valid;
    end
    chk("rw_no_resp", {31'd0, seen_resp}, 32'd0);

    // fresh IF read after reset
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1;
    chk("rw2_if_ready", {31'd0, if_req_ready}, 32'd1);
    tick(); if_req_valid = 1'b0;
    tick();
    tick();
    chk("rw2_resp_valid", {31'd0, if_resp_valid}, 32'd1);
    chk("rw2_resp_rdata", if_resp_rdata, 32'h11111111);
    chk("rw2_resp_err", {31'd0, if_resp_err}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
